vtl_cpu_port: RTL and testbench
===============================

VTL_CPU_PORT -- requirements
Module: vtl_cpu_port

Interface
REQ-001 Parameter FIFO_DEPTH, default 4, number of buffered CPU memory writes (power of two, 2..16).
REQ-002 Parameter IO_BASE, default 8'h44, I/O address of the mode register; the colour register is IO_BASE+1 and the border register is IO_BASE+2.
REQ-003 F14M  in  1  pixel/system clock; the only clock; all state changes on its rising edge.
REQ-004 reset  in  1  asynchronous, active-high reset.
REQ-005 cpu_wr  in  1  single-F14M-cycle write strobe from the CPU bus.
REQ-006 cpu_io  in  1  1 = I/O write, 0 = video RAM write.
REQ-007 cpu_addr  in  14  VRAM address; bits [7:0] are the port number when cpu_io=1.
REQ-008 cpu_data  in  8  write data.
REQ-009 video_busy  in  1  video fetcher owns the RAM bus this cycle.
REQ-010 cpu_wait  out  1  FIFO full; the CPU holds off new memory writes.
REQ-011 overflow  out  1  sticky flag: a memory write was dropped.
REQ-012 vram_we, vram_addr[13:0], vram_data[7:0]  out  VRAM write port, registered.
REQ-013 gr_enabled[1], gr_mode[3], text80[1], fg_color[4], bg_color[4], border_color[4]  out  video mode registers, registered.

Function
REQ-014 A memory write (cpu_wr=1, cpu_io=0) SHALL push {cpu_addr, cpu_data} into the FIFO if count<FIFO_DEPTH, or if a pop occurs in the same cycle.
REQ-015 A memory write arriving when count==FIFO_DEPTH and no pop occurs SHALL be dropped, set overflow=1, and leave the FIFO unchanged.
REQ-016 A pop SHALL occur on an edge where the FIFO is non-empty and video_busy=0; it SHALL register vram_we=1 with the head entry for exactly one cycle.
REQ-017 vram_we SHALL be 0 on every edge without a pop; vram_addr and vram_data SHALL hold their last values.
REQ-018 Latency: a write sampled at edge N into an empty FIFO with video_busy=0 at N+1 SHALL produce vram_we=1 after edge N+1.
REQ-019 Writes SHALL commit in arrival order, one per cycle at most; simultaneous push and pop SHALL leave count unchanged.
REQ-020 cpu_wait SHALL equal (count==FIFO_DEPTH), registered from the post-edge count.
REQ-021 Pointers SHALL wrap modulo FIFO_DEPTH; count SHALL be $clog2(FIFO_DEPTH)+1 bits wide and never exceed FIFO_DEPTH.
REQ-022 An I/O write SHALL bypass the FIFO and update the target register on the same edge.
REQ-023 Port IO_BASE SHALL load gr_mode=data[2:0], gr_enabled=data[3], and text80=data[4].
REQ-024 Port IO_BASE+1 SHALL load fg_color=data[7:4] and bg_color=data[3:0].
REQ-025 Port IO_BASE+2 SHALL load border_color=data[3:0].
REQ-026 I/O writes to other port numbers SHALL be ignored.
REQ-027 cpu_wr with cpu_io=1 SHALL never touch the FIFO, cpu_wait, or overflow.

Reset
REQ-028 Reset SHALL be asynchronous, active-high, and flush the FIFO: count=0, pointers=0, pending writes discarded.
REQ-029 Outputs at reset: vram_we=0, vram_addr=0, vram_data=0, cpu_wait=0, overflow=0.
REQ-030 Mode registers at reset: gr_enabled=0, gr_mode=5, text80=0, fg_color=15, bg_color=1, border_color=9.
REQ-031 Reset asserted mid-commit SHALL force vram_we=0 immediately, without waiting for a clock edge.

Configuration
REQ-032 With VTL_IO_READBACK_EN defined, the block SHALL add inputs cpu_rd[1] and cpu_rd_addr[7:0] and output io_q[8].
REQ-033 In that configuration, io_q SHALL be registered one cycle after cpu_rd: {3'b0,text80,gr_enabled,gr_mode}, {fg,bg}, {4'b0,border}, or {overflow,3'b0,count[3:0]} for ports IO_BASE..IO_BASE+3, and 8'hFF for any other port; reading IO_BASE+3 SHALL clear overflow.
REQ-034 With VTL_IO_READBACK_EN undefined, those ports SHALL not exist and overflow SHALL be cleared only by reset.

Verification
REQ-035 After reset, write cpu_addr=14'h3800, data=8'h41, video_busy=0 -> vram_we=1, addr 3800, data 41 exactly 2 edges after the strobe, for 1 cycle.
REQ-036 Hold video_busy=1 and issue 5 back-to-back writes A0..A4 -> cpu_wait=1 after the 4th write, A4 dropped, overflow=1; release video_busy -> A0..A3 committed in order on 4 consecutive cycles.
REQ-037 With the FIFO full, issue a write in the same cycle video_busy falls -> write accepted, count stays 4, overflow stays 0.
REQ-038 I/O writes 44h<=8'h1D, 45h<=8'h2E, 46h<=8'h03, 47h<=8'hFF -> gr_mode=5, gr_enabled=1, text80=1, fg=2, bg=E, border=3, 47h ignored.
REQ-039 Assert reset with 3 pending entries and vram_we=1 -> vram_we=0 immediately, count=0, registers at defaults, no commit after release.
REQ-040 With VTL_IO_READBACK_EN, after the REQ-036 sequence read 47h -> io_q=8'h80 (FIFO drained, overflow set); read 47h again -> io_q=8'h00.

Source files
------------

// File: rtl/vtl_cpu_port_if.sv
// CPU-side bus bundle for vtl_cpu_port: write strobe, VRAM port, mode regs.
// Readback signals exist only when VTL_IO_READBACK_EN is defined.
interface vtl_cpu_port_if;
  logic        cpu_wr;
  logic        cpu_io;
  logic [13:0] cpu_addr;
  logic [7:0]  cpu_data;
  logic        video_busy;
  logic        cpu_wait;
  logic        overflow;
  logic        vram_we;
  logic [13:0] vram_addr;
  logic [7:0]  vram_data;
  logic        gr_enabled;
  logic [2:0]  gr_mode;
  logic        text80;
  logic [3:0]  fg_color;
  logic [3:0]  bg_color;
  logic [3:0]  border_color;
`ifdef VTL_IO_READBACK_EN
  logic        cpu_rd;
  logic [7:0]  cpu_rd_addr;
  logic [7:0]  io_q;

  modport master (
    output cpu_wr, cpu_io, cpu_addr, cpu_data, video_busy,
    output cpu_rd, cpu_rd_addr,
    input  cpu_wait, overflow, vram_we, vram_addr, vram_data,
    input  gr_enabled, gr_mode, text80,
    input  fg_color, bg_color, border_color, io_q
  );

  modport slave (
    input  cpu_wr, cpu_io, cpu_addr, cpu_data, video_busy,
    input  cpu_rd, cpu_rd_addr,
    output cpu_wait, overflow, vram_we, vram_addr, vram_data,
    output gr_enabled, gr_mode, text80,
    output fg_color, bg_color, border_color, io_q
  );
`else
  modport master (
    output cpu_wr, cpu_io, cpu_addr, cpu_data, video_busy,
    input  cpu_wait, overflow, vram_we, vram_addr, vram_data,
    input  gr_enabled, gr_mode, text80,
    input  fg_color, bg_color, border_color
  );

  modport slave (
    input  cpu_wr, cpu_io, cpu_addr, cpu_data, video_busy,
    output cpu_wait, overflow, vram_we, vram_addr, vram_data,
    output gr_enabled, gr_mode, text80,
    output fg_color, bg_color, border_color
  );
`endif
endinterface

// File: rtl/vtl_cpu_port.sv
// CPU write port: VRAM write FIFO drained when the video fetcher is idle,
// plus mode/colour/border I/O registers. Optional VTL_IO_READBACK_EN.
module vtl_cpu_port #(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter logic [7:0]  IO_BASE    = 8'h44
) (
  input logic F14M,
  input logic reset,
  vtl_cpu_port_if.slave bus
);
  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(FIFO_DEPTH);
  localparam logic [7:0] P_MODE = IO_BASE;
  localparam logic [7:0] P_COL  = IO_BASE + 8'd1;
  localparam logic [7:0] P_BRD  = IO_BASE + 8'd2;

  logic [21:0]   mem_q [FIFO_DEPTH];
  logic [AW-1:0] wp_q, rp_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          wait_q, ovf_q, we_q;
  logic [13:0]   addr_q;
  logic [7:0]    data_q;
  logic          gr_en_q, text80_q;
  logic [2:0]    gr_mode_q;
  logic [3:0]    fg_q, bg_q, brd_q;
  logic          mem_wr, io_wr, pop, push, drop, rd_clr;
  logic [7:0]    io_p;

  always_comb begin
    mem_wr = bus.cpu_wr & ~bus.cpu_io;
    io_wr  = bus.cpu_wr & bus.cpu_io;
    io_p   = bus.cpu_addr[7:0];
    pop    = (cnt_q != '0) & ~bus.video_busy;
    // a full FIFO still accepts when the head leaves on the same edge
    push   = mem_wr & ((cnt_q != FULL) | pop);
    drop   = mem_wr & ~push;
    cnt_d  = cnt_q;
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge F14M) begin
    if (push) mem_q[wp_q] <= {bus.cpu_addr, bus.cpu_data};
  end

  always_ff @(posedge F14M or posedge reset) begin
    if (reset) begin
      wp_q      <= '0;
      rp_q      <= '0;
      cnt_q     <= '0;
      wait_q    <= 1'b0;
      ovf_q     <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      data_q    <= '0;
      gr_en_q   <= 1'b0;
      gr_mode_q <= 3'd5;
      text80_q  <= 1'b0;
      fg_q      <= 4'hF;
      bg_q      <= 4'h1;
      brd_q     <= 4'h9;
    end else begin
      cnt_q  <= cnt_d;
      wait_q <= (cnt_d == FULL);
      ovf_q  <= (ovf_q & ~rd_clr) | drop;
      we_q   <= pop;
      if (push) wp_q <= wp_q + AW'(1);
      if (pop) begin
        rp_q             <= rp_q + AW'(1);
        {addr_q, data_q} <= mem_q[rp_q];
      end
      if (io_wr) begin
        unique case (1'b1)
          (io_p == P_MODE): begin
            gr_mode_q <= bus.cpu_data[2:0];
            gr_en_q   <= bus.cpu_data[3];
            text80_q  <= bus.cpu_data[4];
          end
          (io_p == P_COL): begin
            fg_q <= bus.cpu_data[7:4];
            bg_q <= bus.cpu_data[3:0];
          end
          (io_p == P_BRD): brd_q <= bus.cpu_data[3:0];
          default: ;
        endcase
      end
    end
  end

`ifdef VTL_IO_READBACK_EN
  localparam logic [7:0] P_STAT = IO_BASE + 8'd3;
  logic [7:0] io_q_q;
  logic [7:0] rd_p;
  logic [3:0] cnt4;

  assign rd_p   = bus.cpu_rd_addr;
  assign cnt4   = 4'(cnt_q);
  assign rd_clr = bus.cpu_rd & (rd_p == P_STAT);

  always_ff @(posedge F14M or posedge reset) begin
    if (reset) begin
      io_q_q <= 8'h00;
    end else if (bus.cpu_rd) begin
      unique case (1'b1)
        (rd_p == P_MODE): io_q_q <= {3'b0, text80_q, gr_en_q, gr_mode_q};
        (rd_p == P_COL):  io_q_q <= {fg_q, bg_q};
        (rd_p == P_BRD):  io_q_q <= {4'b0, brd_q};
        (rd_p == P_STAT): io_q_q <= {ovf_q, 3'b0, cnt4};
        default:          io_q_q <= 8'hFF;
      endcase
    end
  end

  assign bus.io_q = io_q_q;
`else
  assign rd_clr = 1'b0;
`endif

  assign bus.cpu_wait     = wait_q;
  assign bus.overflow     = ovf_q;
  assign bus.vram_we      = we_q;
  assign bus.vram_addr    = addr_q;
  assign bus.vram_data    = data_q;
  assign bus.gr_enabled   = gr_en_q;
  assign bus.gr_mode      = gr_mode_q;
  assign bus.text80       = text80_q;
  assign bus.fg_color     = fg_q;
  assign bus.bg_color     = bg_q;
  assign bus.border_color = brd_q;
endmodule

// File: tb/tb_vtl_cpu_port.sv
// Bench for vtl_cpu_port: queue-based reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_vtl_cpu_port;
  localparam int DEPTH = 4;
  localparam logic [7:0] BASE = 8'h44;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_chk = 0;
  int   n_fail = 0;
  logic chk_en = 1'b0;

  always #5 clk = ~clk;

  vtl_cpu_port_if bus ();

  vtl_cpu_port #(.FIFO_DEPTH(DEPTH), .IO_BASE(BASE)) dut (
    .F14M (clk),
    .reset(rst),
    .bus  (bus)
  );

  function automatic void chk(string n, logic [31:0] a, logic [31:0] e);
    n_chk++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s act=%0h exp=%0h t=%0t", n, a, e, $time);
    end
  endfunction

  // reference model
  logic [21:0] q[$];
  logic        e_we, e_ovf, e_wait, e_gen, e_t80;
  logic [13:0] e_addr;
  logic [7:0]  e_data, e_ioq;
  logic [2:0]  e_mode;
  logic [3:0]  e_fg, e_bg, e_brd;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      q.delete();
      e_we = 0; e_ovf = 0; e_wait = 0;
      e_addr = 0; e_data = 0; e_ioq = 0;
      e_gen = 0; e_mode = 5; e_t80 = 0;
      e_fg = 15; e_bg = 1; e_brd = 9;
    end else begin
`ifdef VTL_IO_READBACK_EN
      if (bus.cpu_rd) begin
        case (bus.cpu_rd_addr)
          BASE:        e_ioq = {3'b0, e_t80, e_gen, e_mode};
          BASE + 8'd1: e_ioq = {e_fg, e_bg};
          BASE + 8'd2: e_ioq = {4'b0, e_brd};
          BASE + 8'd3: begin
            e_ioq = {e_ovf, 3'b0, 4'(q.size())};
            e_ovf = 0;
          end
          default:     e_ioq = 8'hFF;
        endcase
      end
`endif
      e_we = 0;
      if (q.size() > 0 && !bus.video_busy) begin
        e_we = 1;
        {e_addr, e_data} = q.pop_front();
      end
      if (bus.cpu_wr && !bus.cpu_io) begin
        if (q.size() < DEPTH) q.push_back({bus.cpu_addr, bus.cpu_data});
        else e_ovf = 1;
      end
      if (bus.cpu_wr && bus.cpu_io) begin
        case (bus.cpu_addr[7:0])
          BASE: begin
            e_mode = bus.cpu_data[2:0];
            e_gen  = bus.cpu_data[3];
            e_t80  = bus.cpu_data[4];
          end
          BASE + 8'd1: {e_fg, e_bg} = bus.cpu_data;
          BASE + 8'd2: e_brd = bus.cpu_data[3:0];
          default: ;
        endcase
      end
      e_wait = (q.size() == DEPTH);
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("m_we", bus.vram_we, e_we);
      chk("m_addr", bus.vram_addr, e_addr);
      chk("m_data", bus.vram_data, e_data);
      chk("m_wait", bus.cpu_wait, e_wait);
      chk("m_ovf", bus.overflow, e_ovf);
      chk("m_mode", {bus.text80, bus.gr_enabled, bus.gr_mode},
          {e_t80, e_gen, e_mode});
      chk("m_col", {bus.fg_color, bus.bg_color, bus.border_color},
          {e_fg, e_bg, e_brd});
`ifdef VTL_IO_READBACK_EN
      chk("m_ioq", bus.io_q, e_ioq);
`endif
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic set_in(logic wr, logic io, logic [13:0] a, logic [7:0] d);
    bus.cpu_wr   = wr;
    bus.cpu_io   = io;
    bus.cpu_addr = a;
    bus.cpu_data = d;
  endtask

  initial begin
    set_in(0, 0, 0, 0);
    bus.video_busy = 1'b0;
`ifdef VTL_IO_READBACK_EN
    bus.cpu_rd      = 1'b0;
    bus.cpu_rd_addr = 8'h00;
`endif
    #1 rst = 1'b1;
    tick();
    chk_en = 1'b1;
    tick();
    rst = 1'b0;

    // reset values
    chk("rst_we", bus.vram_we, 0);
    chk("rst_wait", bus.cpu_wait, 0);
    chk("rst_ovf", bus.overflow, 0);
    chk("rst_addr", bus.vram_addr, 0);
    chk("rst_mode", bus.gr_mode, 5);
    chk("rst_cols", {bus.fg_color, bus.bg_color, bus.border_color}, 12'hF19);

    // single write latency
    set_in(1, 0, 14'h3800, 8'h41);
    tick();
    set_in(0, 0, 0, 0);
    chk("lat_we0", bus.vram_we, 0);
    tick();
    chk("lat_we1", bus.vram_we, 1);
    chk("lat_addr", bus.vram_addr, 14'h3800);
    chk("lat_data", bus.vram_data, 8'h41);
    tick();
    chk("lat_we2", bus.vram_we, 0);
    chk("lat_hold", bus.vram_data, 8'h41);

    // fill, overflow, ordered drain
    bus.video_busy = 1'b1;
    for (int i = 0; i < 5; i++) begin
      set_in(1, 0, 14'h0100 + 14'(i), 8'hA0 + 8'(i));
      tick();
      if (i == 3) begin
        chk("ovf_wait", bus.cpu_wait, 1);
        chk("ovf_pre", bus.overflow, 0);
      end
    end
    set_in(0, 0, 0, 0);
    chk("ovf_set", bus.overflow, 1);
    bus.video_busy = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("drain_we", bus.vram_we, 1);
      chk("drain_data", bus.vram_data, 8'hA0 + 8'(i));
    end
    tick();
    chk("drain_end", bus.vram_we, 0);
    chk("drain_wait", bus.cpu_wait, 0);
`ifdef VTL_IO_READBACK_EN
    bus.cpu_rd = 1'b1;
    bus.cpu_rd_addr = 8'h47;
    tick();
    chk("rb_stat1", bus.io_q, 8'h80);
    tick();
    bus.cpu_rd = 1'b0;
    chk("rb_stat2", bus.io_q, 8'h00);
    chk("rb_ovf_clr", bus.overflow, 0);
`else
    tick();
    chk("ovf_sticky", bus.overflow, 1);
`endif

    // full FIFO write as busy drops
    do_reset();
    bus.video_busy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      set_in(1, 0, 14'h0200 + 14'(i), 8'hC0 + 8'(i));
      tick();
    end
    bus.video_busy = 1'b0;
    set_in(1, 0, 14'h0204, 8'hC4);
    tick();
    set_in(0, 0, 0, 0);
    chk("fullpop_we", bus.vram_we, 1);
    chk("fullpop_d", bus.vram_data, 8'hC0);
    chk("fullpop_wait", bus.cpu_wait, 1);
    chk("fullpop_ovf", bus.overflow, 0);
    for (int i = 1; i < 5; i++) begin
      tick();
      chk("fullpop_drain", bus.vram_data, 8'hC0 + 8'(i));
    end

    // I/O registers
    set_in(1, 1, 14'h3F44, 8'h1D); tick();
    set_in(1, 1, 14'h0045, 8'h2E); tick();
    set_in(1, 1, 14'h0046, 8'h03); tick();
    set_in(1, 1, 14'h0047, 8'hFF); tick();
    set_in(0, 0, 0, 0);
    chk("io_mode", bus.gr_mode, 5);
    chk("io_gen", bus.gr_enabled, 1);
    chk("io_t80", bus.text80, 1);
    chk("io_fgbg", {bus.fg_color, bus.bg_color}, 8'h2E);
    chk("io_brd", bus.border_color, 3);
    chk("io_nofifo", bus.cpu_wait, 0);

    // async reset mid-commit
    do_reset();
    bus.video_busy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      set_in(1, 0, 14'h0300 + 14'(i), 8'hD0 + 8'(i));
      tick();
    end
    set_in(0, 0, 0, 0);
    bus.video_busy = 1'b0;
    tick();
    chk("ar_we_pre", bus.vram_we, 1);
    #1 rst = 1'b1;
    #1;
    chk("ar_we", bus.vram_we, 0);
    chk("ar_wait", bus.cpu_wait, 0);
    chk("ar_cols", {bus.fg_color, bus.bg_color, bus.border_color}, 12'hF19);
    tick();
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("ar_nocommit", bus.vram_we, 0);
    end

    // randomized traffic
    for (int c = 0; c < 3000; c++) begin
      logic [13:0] a;
      logic        io;
      a  = 14'($urandom);
      io = ($urandom_range(0, 3) == 0);
      if (io) a[7:0] = 8'h42 + 8'($urandom_range(0, 6));
      set_in(($urandom_range(0, 2) != 0), io, a, 8'($urandom));
      bus.video_busy = ($urandom_range(0, 9) < ((c / 200) % 2 == 0 ? 3 : 7));
`ifdef VTL_IO_READBACK_EN
      bus.cpu_rd = ($urandom_range(0, 4) == 0);
      bus.cpu_rd_addr = 8'h42 + 8'($urandom_range(0, 6));
`endif
      if ($urandom_range(0, 499) == 0) begin
        #2 rst = 1'b1;
        #1 rst = 1'b0;
      end
      tick();
    end
    set_in(0, 0, 0, 0);
    repeat (8) tick();

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
